// File: rtl/eth_egress_pkt_receiver.sv
// rtl/eth_egress_pkt_receiver.sv - store-and-forward egress packet buffer
// Accepts a tx_* word stream, commits only complete good packets, drops bad ones and keeps stats.
module eth_egress_pkt_receiver #(
   parameter int DEPTH     = 64,
   parameter int MAX_WORDS = 380
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  in_bv,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   input  logic        in_sop,
   input  logic        in_eop,
   output logic [31:0] out_data,
   output logic [1:0]  out_bv,
   output logic        out_sop,
   output logic        out_eop,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] pkt_ok_cnt,
   output logic [15:0] pkt_drop_cnt,
   output logic [15:0] frame_err_cnt,
   output logic [15:0] last_pkt_len
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [15:0] MAXW = 16'(MAX_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_IN_PKT, S_DISCARD} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] commit_ptr_q, commit_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]   word_cnt_q, word_cnt_d;
   logic [15:0]   ok_cnt_q, ok_cnt_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic [15:0]   ferr_cnt_q, ferr_cnt_d;
   logic [15:0]   len_q, len_d;

   logic [35:0]   mem_q [DEPTH];
   logic          we;
   logic [PW-1:0] waddr;
   logic [PW-1:0] base;
   logic          start_new;
   logic [35:0]   wword;
   logic [15:0]   eop_bytes;
   logic          rd_fire;

   assign wword     = {in_sop, in_eop, (in_eop ? in_bv : 2'b00), in_data};
   assign eop_bytes = (in_bv == 2'b00) ? 16'd4 : {14'd0, in_bv};

   assign out_valid = (rd_ptr_q != commit_ptr_q);
   assign {out_sop, out_eop, out_bv, out_data} = mem_q[rd_ptr_q[AW-1:0]];
   assign rd_fire   = out_valid & out_ready;

   assign pkt_ok_cnt    = ok_cnt_q;
   assign pkt_drop_cnt  = drop_cnt_q;
   assign frame_err_cnt = ferr_cnt_q;
   assign last_pkt_len  = len_q;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      rd_ptr_d     = rd_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
      word_cnt_d   = word_cnt_q;
      ok_cnt_d     = ok_cnt_q;
      drop_cnt_d   = drop_cnt_q;
      ferr_cnt_d   = ferr_cnt_q;
      len_d        = len_q;
      we           = 1'b0;
      waddr        = wr_ptr_q;
      base         = wr_ptr_q;
      start_new    = 1'b0;

      if (in_valid) begin
         case (state_q)
            S_IDLE: begin
               if (in_sop) start_new = 1'b1;
               else        ferr_cnt_d = ferr_cnt_q + 16'd1;
            end
            S_IN_PKT: begin
               if (in_sop) begin
                  // Abandon the partial packet; the new sop word reuses its space.
                  drop_cnt_d = drop_cnt_q + 16'd1;
                  wr_ptr_d   = commit_ptr_q;
                  base       = commit_ptr_q;
                  start_new  = 1'b1;
               end else if ((wr_ptr_q - rd_ptr_q) == DEPTH_P) begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
                  wr_ptr_d   = commit_ptr_q;
                  state_d    = in_eop ? S_IDLE : S_DISCARD;
               end else if (!in_eop && (word_cnt_q + 16'd1 >= MAXW)) begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
                  wr_ptr_d   = commit_ptr_q;
                  state_d    = S_DISCARD;
               end else begin
                  we         = 1'b1;
                  waddr      = wr_ptr_q;
                  wr_ptr_d   = wr_ptr_q + PW'(1);
                  word_cnt_d = word_cnt_q + 16'd1;
                  if (in_eop) begin
                     commit_ptr_d = wr_ptr_q + PW'(1);
                     ok_cnt_d     = ok_cnt_q + 16'd1;
                     len_d        = {word_cnt_q[13:0], 2'b00} + eop_bytes;
                     state_d      = S_IDLE;
                  end
               end
            end
            S_DISCARD: begin
               if (in_sop)      start_new = 1'b1;
               else if (in_eop) state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase

         if (start_new) begin
            if ((base - rd_ptr_q) == DEPTH_P) begin
               drop_cnt_d = drop_cnt_d + 16'd1;
               wr_ptr_d   = commit_ptr_q;
               state_d    = in_eop ? S_IDLE : S_DISCARD;
            end else begin
               we       = 1'b1;
               waddr    = base;
               wr_ptr_d = base + PW'(1);
               if (in_eop) begin
                  commit_ptr_d = base + PW'(1);
                  ok_cnt_d     = ok_cnt_q + 16'd1;
                  len_d        = eop_bytes;
                  state_d      = S_IDLE;
               end else begin
                  word_cnt_d = 16'd1;
                  state_d    = S_IN_PKT;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         word_cnt_q   <= '0;
         ok_cnt_q     <= '0;
         drop_cnt_q   <= '0;
         ferr_cnt_q   <= '0;
         len_q        <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         word_cnt_q   <= word_cnt_d;
         ok_cnt_q     <= ok_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         ferr_cnt_q   <= ferr_cnt_d;
         len_q        <= len_d;
      end
   end

   // Storage needs no reset: only words between rd_ptr and commit_ptr are ever visible.
   always_ff @(posedge clk) begin
      if (we && !reset) mem_q[waddr[AW-1:0]] <= wword;
   end

endmodule

// File: tb/tb_eth_egress_pkt_receiver.sv
// tb/tb_eth_egress_pkt_receiver.sv - randomized and directed bench with a queue-based packet model
module tb_eth_egress_pkt_receiver;

   localparam int DEPTH = 64;
   localparam int MAXW  = 380;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  in_bv;
   logic [31:0] in_data;
   logic        in_valid, in_sop, in_eop;
   logic [31:0] out_data;
   logic [1:0]  out_bv;
   logic        out_sop, out_eop, out_valid, out_ready;
   logic [15:0] pkt_ok_cnt, pkt_drop_cnt, frame_err_cnt, last_pkt_len;

   eth_egress_pkt_receiver #(.DEPTH(DEPTH), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .reset(reset),
      .in_bv(in_bv), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .out_data(out_data), .out_bv(out_bv), .out_sop(out_sop), .out_eop(out_eop),
      .out_valid(out_valid), .out_ready(out_ready),
      .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt),
      .frame_err_cnt(frame_err_cnt), .last_pkt_len(last_pkt_len)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int reads = 0;

   // Model: committed words awaiting read, words of the packet being received, receive mode.
   logic [35:0] cq[$];
   logic [35:0] pq[$];
   int          mode;   // 0 between packets, 1 receiving, 2 discarding to eop
   logic [15:0] m_ok, m_drop, m_ferr, m_len;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] nbytes(input logic [1:0] bv);
      return (bv == 2'b00) ? 16'd4 : 16'(bv);
   endfunction

   task automatic model_commit(input logic [1:0] bv);
      m_len = 16'((pq.size() - 1) * 4) + nbytes(bv);
      foreach (pq[i]) cq.push_back(pq[i]);
      pq.delete();
      m_ok++;
      mode = 0;
   endtask

   task automatic model_edge(input logic rd);
      logic [35:0] w;
      logic        start;
      if (reset) begin
         cq.delete(); pq.delete(); mode = 0;
         m_ok = 0; m_drop = 0; m_ferr = 0; m_len = 0;
         return;
      end
      w = {in_sop, in_eop, (in_eop ? in_bv : 2'b00), in_data};
      start = 1'b0;
      if (in_valid) begin
         case (mode)
            0: if (in_sop) start = 1'b1; else m_ferr++;
            1: begin
               if (in_sop) begin
                  m_drop++; pq.delete(); start = 1'b1;
               end else if (cq.size() + pq.size() == DEPTH) begin
                  m_drop++; pq.delete(); mode = in_eop ? 0 : 2;
               end else if (!in_eop && pq.size() + 1 >= MAXW) begin
                  m_drop++; pq.delete(); mode = 2;
               end else begin
                  pq.push_back(w);
                  if (in_eop) model_commit(in_bv);
               end
            end
            default: if (in_sop) start = 1'b1; else if (in_eop) mode = 0;
         endcase
         if (start) begin
            if (cq.size() == DEPTH) begin
               m_drop++; mode = in_eop ? 0 : 2;
            end else begin
               pq.push_back(w);
               if (in_eop) model_commit(in_bv); else mode = 1;
            end
         end
      end
      if (rd) void'(cq.pop_front());
   endtask

   task automatic check_now();
      chk("out_valid", 64'(out_valid), 64'(cq.size() != 0));
      if (cq.size() != 0)
         chk("out_word", 64'({out_sop, out_eop, out_bv, out_data}), 64'(cq[0]));
      chk("pkt_ok_cnt", 64'(pkt_ok_cnt), 64'(m_ok));
      chk("pkt_drop_cnt", 64'(pkt_drop_cnt), 64'(m_drop));
      chk("frame_err_cnt", 64'(frame_err_cnt), 64'(m_ferr));
      chk("last_pkt_len", 64'(last_pkt_len), 64'(m_len));
   endtask

   task automatic tick();
      logic rd;
      rd = (cq.size() != 0) && out_ready && !reset;
      @(posedge clk);
      if (out_valid && out_ready && !reset) reads++;
      model_edge(rd);
      #1;
      check_now();
   endtask

   task automatic drive(input logic v, input logic s, input logic e, input logic [1:0] bv,
                        input logic [31:0] d, input logic rdy);
      in_valid = v; in_sop = s; in_eop = e; in_bv = bv; in_data = d; out_ready = rdy;
      tick();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 2'b00, $urandom, rdy);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(2, 1'b0);
      reset = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic [1:0] bv, input logic rdy);
      for (int i = 0; i < n; i++)
         drive(1'b1, i == 0, i == n - 1, $urandom, $urandom, rdy);
      in_bv = bv;
   endtask

   task automatic send_pkt_bv(input int n, input logic [1:0] bv, input logic rdy);
      for (int i = 0; i < n; i++)
         drive(1'b1, i == 0, i == n - 1, (i == n - 1) ? bv : 2'(i), $urandom, rdy);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      in_bv = 2'b00; in_data = '0; out_ready = 1'b0;
      mode = 0; m_ok = 0; m_drop = 0; m_ferr = 0; m_len = 0;

      // Reset state
      do_reset();
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_ok", 64'(pkt_ok_cnt), 64'd0);

      // Single-word packet
      drive(1'b1, 1'b1, 1'b1, 2'b11, 32'hDEADBEEF, 1'b0);
      chk("one_valid", 64'(out_valid), 64'd1);
      chk("one_data", 64'(out_data), 64'hDEADBEEF);
      chk("one_len", 64'(last_pkt_len), 64'd3);
      chk("one_ok", 64'(pkt_ok_cnt), 64'd1);
      idle(2, 1'b1);

      // Five-word packet, hold ready low until complete
      do_reset();
      send_pkt_bv(5, 2'b00, 1'b0);
      chk("five_len", 64'(last_pkt_len), 64'd20);
      reads = 0;
      idle(7, 1'b1);
      chk("five_reads", 64'(reads), 64'd5);

      // Orphan word, then sop mid-packet
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h11111111, 1'b1);
      chk("orphan_ferr", 64'(frame_err_cnt), 64'd1);
      chk("orphan_empty", 64'(out_valid), 64'd0);
      for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b0, 2'b00, $urandom, 1'b0);
      send_pkt_bv(4, 2'b10, 1'b0);
      chk("midsop_drop", 64'(pkt_drop_cnt), 64'd1);
      chk("midsop_len", 64'(last_pkt_len), 64'd14);
      idle(6, 1'b1);

      // Full boundary: DEPTH-word packet fits, next packet is dropped
      do_reset();
      send_pkt_bv(DEPTH, 2'b01, 1'b0);
      chk("full_ok", 64'(pkt_ok_cnt), 64'd1);
      send_pkt_bv(10, 2'b00, 1'b0);
      chk("full_drop", 64'(pkt_drop_cnt), 64'd1);
      reads = 0;
      idle(DEPTH + 4, 1'b1);
      chk("full_reads", 64'(reads), 64'(DEPTH));
      chk("full_empty", 64'(out_valid), 64'd0);

      // Over-long packet, then a normal one
      do_reset();
      send_pkt_bv(MAXW + 1, 2'b00, 1'b1);
      chk("long_drop", 64'(pkt_drop_cnt), 64'd1);
      chk("long_ok", 64'(pkt_ok_cnt), 64'd0);
      send_pkt_bv(2, 2'b11, 1'b1);
      chk("after_long_len", 64'(last_pkt_len), 64'd7);
      idle(4, 1'b1);

      // Reset mid-packet with committed unread packets
      do_reset();
      send_pkt_bv(2, 2'b00, 1'b0);
      send_pkt_bv(3, 2'b01, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 2'b00, $urandom, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 2'b00, $urandom, 1'b0);
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 2'b00, $urandom, 1'b0);
      reset = 1'b0;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ok", 64'(pkt_ok_cnt), 64'd0);
      send_pkt_bv(3, 2'b10, 1'b1);
      chk("rst_new_len", 64'(last_pkt_len), 64'd10);
      idle(4, 1'b1);

      // Random traffic, alternating drain rates to reach full and empty
      for (int ph = 0; ph < 6; ph++) begin
         for (int c = 0; c < 400; c++)
            drive(($urandom % 4) != 0, ($urandom % 6) == 0, ($urandom % 5) == 0,
                  2'($urandom), $urandom,
                  (ph % 2 == 0) ? (($urandom % 8) == 0) : (($urandom % 3) != 0));
      end
      idle(DEPTH + 4, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
